// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS data-memory bridge.
// State encoding, error fill value and default bus widths.
package mips_bus_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_WR_REQ  = 2'd2,
        ST_RD_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter for an outstanding bus request.
// Raises a one-cycle expire pulse on the last allowed cycle without ack.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count cycles spent waiting; restart whenever no request is pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the single-cycle core load/store path to a req/ack bus.
// Loads stall the core; stores are posted through a one-entry buffer.
module dmem_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemR,
    input  logic              MemW,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Stall,
    output logic              BusErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    logic [DATA_W-1:0] r_data_out;
    logic              r_bus_err;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_ack;
    logic w_in_req;
    logic w_expire;

    assign w_ack    = mem_ack && r_req;
    assign w_in_req = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .i_clk    (Clk),
        .i_rst_n  (Reset),
        .i_clr    (!w_in_req),
        .i_en     (w_in_req && !w_ack),
        .o_expire (w_expire)
    );

    // Transaction sequencer with registered bus and core outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_data_out <= '0;
            r_bus_err  <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (MemW) begin
                        r_addr  <= DataAdr;
                        r_wdata <= DataIn;
                        r_we    <= 1'b1;
                        r_req   <= 1'b1;
                        r_state <= ST_WR_REQ;
                        if (MemR) begin
                            r_bus_err <= 1'b1;
                        end
                    end else if (MemR) begin
                        r_addr  <= DataAdr;
                        r_we    <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (w_ack) begin
                        r_data_out <= mem_rdata;
                        r_req      <= 1'b0;
                        r_state    <= ST_RD_DONE;
                    end else if (w_expire) begin
                        r_data_out <= DATA_W'(ERR_DATA);
                        r_req      <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_state    <= ST_RD_DONE;
                    end
                end
                ST_WR_REQ: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RD_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Stall = (MemR && (r_state != ST_RD_DONE))
                || (MemW && (r_state != ST_IDLE));

    assign DataOut   = r_data_out;
    assign BusErr    = r_bus_err;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge.
// Drivers queue expected bus/load results; monitors pop and compare.
module tb_dmem_bridge;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          Clk   = 1'b0;
    logic          Reset = 1'b1;
    logic          MemR  = 1'b0;
    logic          MemW  = 1'b0;
    logic [AW-1:0] DataAdr = '0;
    logic [DW-1:0] DataIn  = '0;
    logic [DW-1:0] DataOut;
    logic          Stall;
    logic          BusErr;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack   = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    dmem_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MemR      (MemR),
        .MemW      (MemW),
        .DataAdr   (DataAdr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            len;
    } bus_t;

    bus_t          bus_q[$];
    logic [DW-1:0] load_q[$];

    int n_vec = 0;
    int n_err = 0;

    int            ack_delay = 0;
    bit            no_ack    = 1'b0;
    logic [DW-1:0] rd_val    = '0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: ack after ack_delay cycles of mem_req.
    int rcnt = 0;
    always @(posedge Clk) begin
        #1;
        if (mem_req && !mem_ack && !no_ack && rcnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_val;
        end else begin
            mem_ack = 1'b0;
        end
        if (mem_req) rcnt++;
        else rcnt = 0;
    end

    // Bus monitor: checks each request against the queue, its stability and length.
    logic                 prev_req = 1'b0;
    bus_t                 cur;
    int                   blen = 0;
    logic [AW+DW:0]       snap;
    always @(negedge Clk) begin
        if (mem_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 64'(1), 64'(0));
                cur = '{we: 1'b0, addr: '0, wdata: '0, len: 0};
            end else begin
                cur = bus_q.pop_front();
                check("bus_we", 64'(mem_we), 64'(cur.we));
                check("bus_addr", 64'(mem_addr), 64'(cur.addr));
                if (cur.we) check("bus_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end
            blen = 1;
            snap = {mem_we, mem_addr, mem_wdata};
        end else if (mem_req && prev_req) begin
            blen++;
            check("bus_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(snap));
        end else if (!mem_req && prev_req) begin
            check("bus_req_len", 64'(blen), 64'(cur.len));
        end
        prev_req = mem_req;
    end

    // Load monitor: the commit cycle of a load must present the expected data.
    always @(negedge Clk) begin
        if (Reset && MemR && !Stall) begin
            if (load_q.size() == 0) check("load_unexpected", 64'(1), 64'(0));
            else check("load_data", 64'(DataOut), 64'(load_q.pop_front()));
        end
    end

    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input int exp_len, input int exp_stall);
        int st = 0;
        bit done = 1'b0;
        MemR    = 1'b1;
        DataAdr = a;
        load_q.push_back(exp);
        bus_q.push_back('{we: 1'b0, addr: a, wdata: '0, len: exp_len});
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clk);
            if (!Stall) begin
                done = 1'b1;
            end else begin
                st++;
                @(posedge Clk);
                #1;
            end
        end
        check("load_done", 64'(done), 64'(1));
        check("load_stall_cycles", 64'(st), 64'(exp_stall));
        @(posedge Clk);
        #1;
        MemR = 1'b0;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int exp_len);
        MemW    = 1'b1;
        DataAdr = a;
        DataIn  = d;
        bus_q.push_back('{we: 1'b1, addr: a, wdata: d, len: exp_len});
        @(negedge Clk);
        check("store_stall", 64'(Stall), 64'(0));
        @(posedge Clk);
        #1;
        MemW = 1'b0;
    endtask

    task automatic wait_bus_idle(input string nm);
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge Clk);
            if (!mem_req) idle = 1'b1;
        end
        check(nm, 64'(idle), 64'(1));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 Reset = 1'b0;
        #20;
        check("rst_data_err", 64'({DataOut, BusErr, Stall}), 64'(0));
        check("rst_bus", 64'({mem_req, mem_we, mem_addr}), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Load acked in its first request cycle.
        ack_delay = 0;
        rd_val    = 32'h1234_5678;
        do_load(5'd4, 32'h1234_5678, 1, 2);

        // Posted store with a three-cycle bus handshake.
        ack_delay = 2;
        do_store(5'd3, 32'hA5A5_A5A5, 3);
        check("store_posted_req", 64'({mem_req, mem_we}), 64'(3));
        wait_bus_idle("store_drain");

        // Store followed directly by a load.
        rd_val = 32'hCAFE_0001;
        do_store(5'd10, 32'h1111_2222, 3);
        do_load(5'd11, 32'hCAFE_0001, 3, 7);
        check("no_err_yet", 64'(BusErr), 64'(0));

        // Ack on the final allowed cycle beats the timeout.
        ack_delay = TO - 1;
        rd_val    = 32'h5555_AAAA;
        do_load(5'd1, 32'h5555_AAAA, TO, TO + 1);
        check("late_ack_no_err", 64'(BusErr), 64'(0));

        // Load with no ack times out.
        no_ack = 1'b1;
        do_load(5'd2, 32'hDEAD_BEEF, TO, TO + 1);
        check("timeout_err", 64'(BusErr), 64'(1));
        no_ack    = 1'b0;
        ack_delay = 1;
        rd_val    = 32'h0F0F_0F0F;
        do_load(5'd6, 32'h0F0F_0F0F, 2, 3);
        ack_delay = 0;
        do_store(5'd7, 32'h7777_0000, 1);
        wait_bus_idle("store2_drain");
        check("err_sticky", 64'(BusErr), 64'(1));

        // Reset clears the sticky flag.
        Reset = 1'b0;
        #1;
        check("err_cleared", 64'(BusErr), 64'(0));
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Simultaneous load and store: handled as a write plus error.
        ack_delay = 0;
        MemR    = 1'b1;
        MemW    = 1'b1;
        DataAdr = 5'd7;
        DataIn  = 32'h0BAD_F00D;
        bus_q.push_back('{we: 1'b1, addr: 5'd7, wdata: 32'h0BAD_F00D, len: 1});
        @(posedge Clk);
        #1;
        MemR = 1'b0;
        MemW = 1'b0;
        check("illegal_wr", 64'({mem_req, mem_we}), 64'(3));
        check("illegal_err", 64'(BusErr), 64'(1));
        wait_bus_idle("illegal_drain");

        // Reset asserted while a read is outstanding.
        no_ack  = 1'b1;
        MemR    = 1'b1;
        DataAdr = 5'd9;
        @(posedge Clk);
        #1;
        check("rd_req_active", 64'(mem_req), 64'(1));
        #1;
        Reset = 1'b0;
        MemR  = 1'b0;
        #1;
        check("midrst_data_err", 64'({DataOut, BusErr, Stall}), 64'(0));
        check("midrst_bus", 64'({mem_req, mem_we, mem_addr}), 64'(0));
        check("midrst_wdata", 64'(mem_wdata), 64'(0));
        @(posedge Clk);
        #1;
        Reset  = 1'b1;
        no_ack = 1'b0;
        @(posedge Clk);
        #1;
        ack_delay = 0;
        rd_val    = 32'h8765_4321;
        do_load(5'd12, 32'h8765_4321, 1, 2);
        check("final_no_err", 64'(BusErr), 64'(0));

        repeat (2) @(posedge Clk);
        check("bus_q_empty", 64'(bus_q.size()), 64'(0));
        check("load_q_empty", 64'(load_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
